univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning register width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter CW, default $clog2(WIDTH)+1, meaning bit counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset; asserts on its falling edge and acts independently of clk.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear, active-high.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The block SHALL have port sin_r, input, 1 bit: serial data entering at the MSB during shift right.
REQ-008 The block SHALL have port sin_l, input, 1 bit: serial data entering at the LSB during shift left.
REQ-009 The block SHALL have port d_par, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port out, output, WIDTH bits: registered register contents.
REQ-011 The block SHALL have port sout_r, output, 1 bit: serial-out for right shift, equal to out[0].
REQ-012 The block SHALL have port sout_l, output, 1 bit: serial-out for left shift, equal to out[WIDTH-1].
REQ-013 The block SHALL have port bit_cnt, output, CW bits: count of shifts since the last word boundary.
REQ-014 The block SHALL have port word_valid, output, 1 bit: registered one-cycle pulse marking a completed serial word.

Function
REQ-015 Priority per edge SHALL be: reset, then clr, then mode.
REQ-016 On clr=1, the block SHALL set out=0, bit_cnt=0 and word_valid=0, regardless of mode.
REQ-017 In hold (00), out and bit_cnt SHALL be unchanged and word_valid SHALL be 0.
REQ-018 In shift right (01): out[i] <= out[i+1] for i=0..WIDTH-2, and out[WIDTH-1] <= sin_r.
REQ-019 In shift left (10): out[i] <= out[i-1] for i=1..WIDTH-1, and out[0] <= sin_l.
REQ-020 In parallel load (11): out <= d_par, bit_cnt <= 0, word_valid <= 0.
REQ-021 Each shift in either direction SHALL increment bit_cnt by 1.
REQ-022 When a shift occurs with bit_cnt==WIDTH-1, bit_cnt SHALL wrap to 0 and word_valid SHALL be 1 for the following cycle only; the new out holds the complete word in that same cycle.
REQ-023 word_valid SHALL be 0 in every cycle not described in REQ-022; back-to-back words SHALL give one pulse every WIDTH shift cycles.
REQ-024 A change of shift direction mid-word SHALL NOT reset bit_cnt; counting continues.
REQ-025 Hold cycles mid-word SHALL freeze bit_cnt; the word completes after WIDTH total shifts.
REQ-026 sout_r and sout_l SHALL be combinational taps of out with no additional latency.
REQ-027 The bit_cnt value SHALL never exceed WIDTH-1.

Reset
REQ-028 While reset=0, the block SHALL force out=0, bit_cnt=0 and word_valid=0 immediately, without waiting for a clk edge.
REQ-029 Reset asserted mid-word SHALL discard the partial word and SHALL NOT emit word_valid.
REQ-030 After reset deasserts, the first rising clk edge SHALL operate normally.

Verification (WIDTH=4)
REQ-031 Check: drive reset=0 with arbitrary inputs -> out=0000, bit_cnt=0, word_valid=0 before any clk edge.
REQ-032 Check: mode=01 with sin_r=1,0,1,1 over 4 edges -> out=1000, 0100, 1010, 1101; word_valid=1 only in the cycle showing 1101; bit_cnt=0.
REQ-033 Check: load d_par=1010, then mode=10 with sin_l=1 -> out=0101, bit_cnt=1, word_valid=0.
REQ-034 Check: 2 right shifts, then 3 hold cycles (bit_cnt stays 2), then 2 left shifts -> word_valid pulses after the 4th shift.
REQ-035 Check: clr=1 with mode=11 and d_par=1111 -> out=0000, bit_cnt=0 (clr wins).
REQ-036 Check: reset pulsed low between edges while bit_cnt=3 -> immediate out=0 and bit_cnt=0; the next shift gives bit_cnt=1 and no word_valid.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load.
// Tracks shifts per serial word and pulses word_valid on completion.
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d_par,
    output logic [WIDTH-1:0] out,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    bit_cnt,
    output logic             word_valid
);

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_SHR  = 2'b01;
    localparam logic [1:0] M_SHL  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wv_q, wv_d;
    logic             shift;

    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        wv_d  = 1'b0;
        shift = 1'b0;
        if (clr) begin
            out_d = '0;
            cnt_d = '0;
        end else begin
            unique case (mode)
                M_HOLD: ;
                M_SHR: begin
                    out_d = {sin_r, out_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                M_SHL: begin
                    out_d = {out_q[WIDTH-2:0], sin_l};
                    shift = 1'b1;
                end
                M_LOAD: begin
                    out_d = d_par;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        // Direction changes share one counter; only a load or clear restarts it.
        if (shift) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                wv_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            cnt_q <= '0;
            wv_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
            wv_q  <= wv_d;
        end
    end

    assign out        = out_q;
    assign sout_r     = out_q[0];
    assign sout_l     = out_q[WIDTH-1];
    assign bit_cnt    = cnt_q;
    assign word_valid = wv_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios then random traffic
// against an arithmetic word/shift-count model.
module tb_univ_shift_reg;

    localparam int W    = 4;
    localparam int CWID = $clog2(W) + 1;
    localparam int MASK = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            clr;
    logic [1:0]      mode;
    logic            sin_r;
    logic            sin_l;
    logic [W-1:0]    d_par;
    logic [W-1:0]    dout;
    logic            sout_r;
    logic            sout_l;
    logic [CWID-1:0] bit_cnt;
    logic            word_valid;

    int total = 0;
    int bad   = 0;

    int m_out;
    int m_cnt;
    int m_wv;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .d_par      (d_par),
        .out        (dout),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .bit_cnt    (bit_cnt),
        .word_valid (word_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"}, 32'(dout), 32'(m_out));
        chk({tag, ".sout_r"}, 32'(sout_r), 32'(m_out & 1));
        chk({tag, ".sout_l"}, 32'(sout_l), 32'((m_out >> (W - 1)) & 1));
        chk({tag, ".cnt"}, 32'(bit_cnt), 32'(m_cnt));
        chk({tag, ".wv"}, 32'(word_valid), 32'(m_wv));
    endtask

    task automatic model_reset();
        m_out = 0;
        m_cnt = 0;
        m_wv  = 0;
    endtask

    // One clock edge with the given inputs; model tracks total shifts per word.
    task automatic step(input string tag, input bit c, input logic [1:0] md,
                        input bit sr, input bit sl, input int dp);
        bit shifted;
        clr   = c;
        mode  = md;
        sin_r = sr;
        sin_l = sl;
        d_par = W'(dp);
        @(posedge clk);
        shifted = 1'b0;
        m_wv = 0;
        if (c) begin
            m_out = 0;
            m_cnt = 0;
        end else if (md == 2'd1) begin
            m_out = (m_out >> 1) | (int'(sr) << (W - 1));
            shifted = 1'b1;
        end else if (md == 2'd2) begin
            m_out = ((m_out << 1) | int'(sl)) & MASK;
            shifted = 1'b1;
        end else if (md == 2'd3) begin
            m_out = dp & MASK;
            m_cnt = 0;
        end
        if (shifted) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == W) begin
                m_cnt = 0;
                m_wv = 1;
            end
        end
        #1;
        chk_model(tag);
    endtask

    // Reset pulse between edges, checked before the next edge arrives.
    task automatic areset_pulse(input string tag);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_model(tag);
        reset = 1'b1;
    endtask

    initial begin
        int sr_seq[4];
        int exp_out[4];
        reset = 1'b0;
        clr   = 1'b0;
        mode  = 2'b11;
        sin_r = 1'b1;
        sin_l = 1'b1;
        d_par = 4'hF;
        model_reset();
        #2;
        chk_model("rst_async");
        #10 reset = 1'b1;

        sr_seq  = '{1, 0, 1, 1};
        exp_out = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
        for (int i = 0; i < 4; i++) begin
            step("shr_word", 1'b0, 2'b01, sr_seq[i][0], 1'b0, 0);
            chk("shr_word.const", 32'(dout), 32'(exp_out[i]));
            chk("shr_word.wvconst", 32'(word_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        step("hold_after_word", 1'b0, 2'b00, 1'b0, 1'b0, 0);

        step("load_a", 1'b0, 2'b11, 1'b0, 1'b0, 4'b1010);
        step("shl_1", 1'b0, 2'b10, 1'b0, 1'b1, 0);
        chk("shl_1.const", 32'(dout), 32'(4'b0101));
        chk("shl_1.cntconst", 32'(bit_cnt), 32'd1);

        step("load_z", 1'b0, 2'b11, 1'b0, 1'b0, 0);
        step("mix_r1", 1'b0, 2'b01, 1'b1, 1'b0, 0);
        step("mix_r2", 1'b0, 2'b01, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            step("mix_hold", 1'b0, 2'b00, 1'b1, 1'b1, 4'hF);
            chk("mix_hold.cnt2", 32'(bit_cnt), 32'd2);
        end
        step("mix_l1", 1'b0, 2'b10, 1'b0, 1'b1, 0);
        chk("mix_l1.nowv", 32'(word_valid), 32'd0);
        step("mix_l2", 1'b0, 2'b10, 1'b0, 1'b0, 0);
        chk("mix_l2.wv", 32'(word_valid), 32'd1);

        step("clr_pre", 1'b0, 2'b01, 1'b1, 1'b0, 0);
        step("clr_wins", 1'b1, 2'b11, 1'b1, 1'b1, 4'hF);
        chk("clr_wins.const", 32'(dout), 32'd0);

        for (int i = 0; i < 3; i++)
            step("pre_rst", 1'b0, 2'b01, 1'b1, 1'b0, 0);
        chk("pre_rst.cnt3", 32'(bit_cnt), 32'd3);
        areset_pulse("rst_mid");
        step("post_rst", 1'b0, 2'b01, 1'b1, 1'b0, 0);
        chk("post_rst.cnt1", 32'(bit_cnt), 32'd1);
        chk("post_rst.nowv", 32'(word_valid), 32'd0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(31) == 0)
                areset_pulse("rnd_rst");
            step("rnd", $urandom_range(15) == 0, 2'($urandom_range(3)),
                 1'($urandom), 1'($urandom), int'($urandom_range(MASK)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
